// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared widths, constants and the stage-1 register layout for the
//            FP normalize/round stage.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Single-precision defaults; switch both to 52/11 for a double datapath.
  localparam int c_size_mantissa = 23;
  localparam int c_size_exponent = 8;

  // Exponent bias and the reserved all-ones exponent (infinity/NaN).
  localparam int                         c_bias         = (1 << (c_size_exponent - 1)) - 1;
  localparam logic [c_size_exponent-1:0] c_exp_all_ones = '1;

  // Normalized operand held between the normalize and round stages.
  // The working exponent never drops below 1 (left shifts are clamped at the
  // denormal scale), so it is kept unsigned with two bits of headroom for the
  // carry and rounding increments.
  typedef struct packed {
    logic                         sign;
    logic [c_size_exponent+1:0]   exponent;
    logic [c_size_mantissa:0]     mantissa;  // hidden bit + fraction
    logic                         guard;
    logic                         sticky;
    logic                         zero;
  } stage1_t;

endpackage
`default_nettype wire

// File: rtl/leading_zero_counter.sv
`default_nettype none
// ============================================================================
// Module   : leading_zero_counter
// Brief    : Counts leading zeros of a SIZE_MANTISSA+2 bit vector
//            (carry, hidden, fraction). All-zero input returns the width.
// Revision : 1.0 - initial release
// ============================================================================
module leading_zero_counter #(
  parameter int SIZE_MANTISSA = 23
) (
  input  logic [SIZE_MANTISSA+1:0]             value,
  output logic [$clog2(SIZE_MANTISSA+2)-1:0]   count
);

  localparam int c_width   = SIZE_MANTISSA + 2;
  localparam int c_count_w = $clog2(SIZE_MANTISSA + 2);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count = c_count_w'(c_width);
    for (int i = 0; i < c_width; i++) begin
      if (value[i]) begin
        count = c_count_w'(c_width - 1 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize_round
// Brief    : Two-stage normalize + round-to-nearest-even back end for the FP
//            add/sub/mul cores, with valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module fp_normalize_round
  import fp_pkg::*;
#(
  // The stage-1 register layout comes from fp_pkg, so these must match the
  // package widths.
  parameter int SIZE_MANTISSA = c_size_mantissa,
  parameter int SIZE_EXPONENT = c_size_exponent
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 sign_in,
  input  logic [SIZE_EXPONENT-1:0]             exponent_in,
  input  logic [SIZE_MANTISSA+2:0]             mantissa_in,
  input  logic                                 sticky_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SIZE_EXPONENT+SIZE_MANTISSA:0] result,
  output logic                                 overflow,
  output logic                                 underflow,
  output logic                                 zero
);

  localparam int c_ew  = SIZE_EXPONENT + 2;
  localparam int c_lzw = $clog2(SIZE_MANTISSA + 2);

  // ---------------------------------------------------------------- handshake
  logic r_valid1;
  logic r_valid2;
  logic w_s2_ready;

  assign w_s2_ready = !r_valid2 || out_ready;
  assign in_ready   = !r_valid1 || w_s2_ready;
  assign out_valid  = r_valid2;

  // ---------------------------------------------------------- stage 1: shift
  logic [c_lzw-1:0]           w_lz;
  logic [c_ew-1:0]            w_exp_in;
  logic [c_ew-1:0]            w_lz_ext;
  logic [c_ew-1:0]            w_room;
  logic [c_ew-1:0]            w_shift;
  logic [SIZE_MANTISSA+1:0]   w_shl;
  stage1_t                    w_s1;
  stage1_t                    r_s1;

  leading_zero_counter #(
    .SIZE_MANTISSA (SIZE_MANTISSA)
  ) u_lzc (
    .value (mantissa_in[SIZE_MANTISSA+2:1]),
    .count (w_lz)
  );

  // A zero exponent field is a denormal and shares the scale of exponent 1.
  assign w_exp_in = (exponent_in == '0) ? c_ew'(1) : {2'b00, exponent_in};

  // Left shift is the leading-zero distance to the hidden bit, clamped so the
  // exponent never goes below 1 (the result then stays denormal).
  assign w_lz_ext = c_ew'(w_lz) - c_ew'(1);
  assign w_room   = w_exp_in - c_ew'(1);
  assign w_shift  = (w_lz_ext < w_room) ? w_lz_ext : w_room;

  // Hidden, fraction and guard move together; the guard becomes a data bit.
  assign w_shl = mantissa_in[SIZE_MANTISSA+1:0] << w_shift;

  // Normalize: carry -> right shift by one, otherwise clamped left shift.
  always_comb begin
    w_s1      = '0;
    w_s1.sign = sign_in;
    if (mantissa_in[SIZE_MANTISSA+2:1] == '0) begin
      w_s1.zero = 1'b1;
    end else if (mantissa_in[SIZE_MANTISSA+2]) begin
      w_s1.mantissa = mantissa_in[SIZE_MANTISSA+2:2];
      w_s1.guard    = mantissa_in[1];
      w_s1.sticky   = sticky_in | mantissa_in[0];
      w_s1.exponent = w_exp_in + c_ew'(1);
    end else begin
      w_s1.mantissa = w_shl[SIZE_MANTISSA+1:1];
      w_s1.guard    = w_shl[0];
      w_s1.sticky   = sticky_in;
      w_s1.exponent = w_exp_in - w_shift;
    end
  end

  // Stage-1 register: loads whenever it is empty or stage 2 can take its data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid1 <= 1'b0;
      r_s1     <= '0;
    end else if (in_ready) begin
      r_valid1 <= in_valid;
      if (in_valid) begin
        r_s1 <= w_s1;
      end
    end
  end

  // ---------------------------------------------------------- stage 2: round
  logic                                 w_round_up;
  logic [SIZE_MANTISSA+1:0]             w_sum;
  logic [SIZE_MANTISSA:0]               w_mant;
  logic [c_ew-1:0]                      w_exp;
  logic [c_ew-1:0]                      w_field_exp;
  logic [SIZE_EXPONENT+SIZE_MANTISSA:0] w_result;
  logic                                 w_overflow;
  logic                                 w_underflow;
  logic                                 w_zero;
  logic [SIZE_EXPONENT+SIZE_MANTISSA:0] r_result;
  logic                                 r_overflow;
  logic                                 r_underflow;
  logic                                 r_zero;

  // RNE increment, carry renormalization, then pack with overflow/zero cases.
  // A denormal whose increment reaches the hidden bit naturally reads back
  // exponent field 1 because its working exponent is already 1.
  always_comb begin
    w_round_up = r_s1.guard & (r_s1.sticky | r_s1.mantissa[0]);
    w_sum      = {1'b0, r_s1.mantissa} + {{(SIZE_MANTISSA+1){1'b0}}, w_round_up};
    if (w_sum[SIZE_MANTISSA+1]) begin
      w_mant = w_sum[SIZE_MANTISSA+1:1];
      w_exp  = r_s1.exponent + c_ew'(1);
    end else begin
      w_mant = w_sum[SIZE_MANTISSA:0];
      w_exp  = r_s1.exponent;
    end
    w_field_exp = w_mant[SIZE_MANTISSA] ? w_exp : '0;

    w_result    = {r_s1.sign, w_field_exp[SIZE_EXPONENT-1:0], w_mant[SIZE_MANTISSA-1:0]};
    w_overflow  = 1'b0;
    w_underflow = 1'b0;
    w_zero      = 1'b0;
    if (r_s1.zero) begin
      w_result = {r_s1.sign, {(SIZE_EXPONENT+SIZE_MANTISSA){1'b0}}};
      w_zero   = 1'b1;
    end else if (w_field_exp >= c_ew'(c_exp_all_ones)) begin
      w_result   = {r_s1.sign, c_exp_all_ones, {SIZE_MANTISSA{1'b0}}};
      w_overflow = 1'b1;
    end else begin
      w_underflow = (w_field_exp == '0) && (r_s1.guard | r_s1.sticky);
    end
  end

  // Output register: result and flags move together and hold under stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid2    <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_s2_ready) begin
      r_valid2 <= r_valid1;
      if (r_valid1) begin
        r_result    <= w_result;
        r_overflow  <= w_overflow;
        r_underflow <= w_underflow;
        r_zero      <= w_zero;
      end
    end
  end

  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_normalize_round
// Brief    : Self-checking bench for fp_normalize_round (single precision),
//            with a value-level reference model of normalize + RNE rounding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_round;

  localparam int S = 23;
  localparam int E = 8;

  logic         clock       = 1'b0;
  logic         reset       = 1'b0;
  logic         in_valid    = 1'b0;
  logic         in_ready;
  logic         sign_in     = 1'b0;
  logic [E-1:0] exponent_in = '0;
  logic [S+2:0] mantissa_in = '0;
  logic         sticky_in   = 1'b0;
  logic         out_valid;
  logic         out_ready   = 1'b1;
  logic [E+S:0] result;
  logic         overflow;
  logic         underflow;
  logic         zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        uf;
    logic        z;
  } exp_t;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [25:0] m;
    logic        st;
  } op_t;

  always #5 clock = ~clock;

  fp_normalize_round dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign_in     (sign_in),
    .exponent_in (exponent_in),
    .mantissa_in (mantissa_in),
    .sticky_in   (sticky_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .overflow    (overflow),
    .underflow   (underflow),
    .zero        (zero)
  );

  // Reference: locate the MSB of the whole operand, pick the target binade
  // (clamped at the denormal scale), shift to 24 significand bits, apply RNE.
  function automatic exp_t model(input op_t op);
    exp_t   r;
    longint mm, q;
    int     e, p, et, k, fld;
    logic   g, stk, up;
    r = '0;
    if (op.m[25:1] == 25'd0) begin
      r.res = {op.s, 31'd0};
      r.z   = 1'b1;
      return r;
    end
    e  = (op.e == 8'd0) ? 1 : int'(op.e);
    p  = 25;
    while (!op.m[p]) p--;
    et = e + p - 24;
    if (et < 1) et = 1;
    k  = et - e + 1;
    mm = longint'(op.m);
    if (k >= 1) begin
      q   = mm >> k;
      g   = ((mm >> (k - 1)) & 64'd1) != 0;
      stk = op.st || ((mm & ((64'd1 << (k - 1)) - 1)) != 0);
    end else begin
      q   = mm << (-k);
      g   = 1'b0;
      stk = op.st;
    end
    up = g && (stk || q[0]);
    q  = q + longint'(up);
    if (q >= (64'd1 << 24)) begin
      q  = q >> 1;
      et = et + 1;
    end
    fld = (q >= (64'd1 << 23)) ? et : 0;
    if (fld >= 255) begin
      r.res = {op.s, 8'hFF, 23'd0};
      r.ov  = 1'b1;
    end else begin
      r.res = {op.s, 8'(fld), 23'(q)};
      r.uf  = (fld == 0) && (g || stk);
    end
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       op.e = 8'd0;
      1:       op.e = 8'd1;
      2:       op.e = 8'hFF;
      3:       op.e = 8'hFE;
      default: op.e = 8'($urandom_range(0, 255));
    endcase
    op.m = 26'($urandom() >> $urandom_range(6, 31));
    if ($urandom_range(0, 31) == 0) op.m = 26'($urandom_range(0, 1));
    op.st = 1'($urandom_range(0, 1));
    return op;
  endfunction

  task automatic drive(input op_t op);
    sign_in     = op.s;
    exponent_in = op.e;
    mantissa_in = op.m;
    sticky_in   = op.st;
  endtask

  function automatic exp_t observed();
    return {result, overflow, underflow, zero};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({out_valid, result, overflow, underflow, zero} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b res=%h flags=%b%b%b, expected all zero",
               out_valid, result, overflow, underflow, zero);
    end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    op_t   ops[10];
    exp_t  want[10];
    string names[10];
    ops[0] = '{s:1'b0, e:8'd127, m:26'h1000000, st:1'b0}; want[0] = '{res:32'h3F800000, ov:1'b0, uf:1'b0, z:1'b0}; names[0] = "normal";
    ops[1] = '{s:1'b0, e:8'd127, m:26'h2000000, st:1'b0}; want[1] = '{res:32'h40000000, ov:1'b0, uf:1'b0, z:1'b0}; names[1] = "carry";
    ops[2] = '{s:1'b0, e:8'd127, m:26'h0800000, st:1'b0}; want[2] = '{res:32'h3F000000, ov:1'b0, uf:1'b0, z:1'b0}; names[2] = "left_shift";
    ops[3] = '{s:1'b0, e:8'd127, m:26'h1000001, st:1'b0}; want[3] = '{res:32'h3F800000, ov:1'b0, uf:1'b0, z:1'b0}; names[3] = "tie_even";
    ops[4] = '{s:1'b0, e:8'd127, m:26'h1000003, st:1'b0}; want[4] = '{res:32'h3F800002, ov:1'b0, uf:1'b0, z:1'b0}; names[4] = "round_up";
    ops[5] = '{s:1'b0, e:8'd127, m:26'h1FFFFFF, st:1'b0}; want[5] = '{res:32'h40000000, ov:1'b0, uf:1'b0, z:1'b0}; names[5] = "round_carry";
    ops[6] = '{s:1'b0, e:8'd254, m:26'h2000000, st:1'b0}; want[6] = '{res:32'h7F800000, ov:1'b1, uf:1'b0, z:1'b0}; names[6] = "overflow";
    ops[7] = '{s:1'b0, e:8'd1,   m:26'h0400000, st:1'b0}; want[7] = '{res:32'h00200000, ov:1'b0, uf:1'b0, z:1'b0}; names[7] = "denormal";
    ops[8] = '{s:1'b1, e:8'h55,  m:26'h0000000, st:1'b1}; want[8] = '{res:32'h80000000, ov:1'b0, uf:1'b0, z:1'b1}; names[8] = "zero";
    ops[9] = '{s:1'b0, e:8'd1,   m:26'h0000003, st:1'b0}; want[9] = '{res:32'h00000002, ov:1'b0, uf:1'b1, z:1'b0}; names[9] = "denorm_inexact";
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      drive(ops[i]);
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b1 || observed() !== want[i]) begin
        n_bad++;
        $display("FAIL %s: got valid=%b res=%h ov=%b uf=%b z=%b, expected valid=1 res=%h ov=%b uf=%b z=%b",
                 names[i], out_valid, result, overflow, underflow, zero,
                 want[i].res, want[i].ov, want[i].uf, want[i].z);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    op_t  cur;
    exp_t q[$];
    exp_t w;
    exp_t held;
    int   issued = 0;
    int   got    = 0;
    bit   acc    = 0;
    bit   stalled = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clock);
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || observed() !== held) begin
          n_bad++;
          $display("FAIL bp_hold: got valid=%b res=%h, expected valid=1 res=%h", out_valid, result, held.res);
        end
      end
      out_ready = (c >= 5);
      if (acc) in_valid = 1'b0;
      if (!in_valid && issued < 4) begin
        cur = rand_op();
        drive(cur);
        in_valid = 1'b1;
        issued++;
      end
      #1;
      if (c == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_in_ready: got %b, expected 0 with both stages full", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        got++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra: got res=%h with nothing outstanding", result);
        end else begin
          w = q.pop_front();
          if (observed() !== w) begin
            n_bad++;
            $display("FAIL bp_data: got res=%h flags=%b%b%b, expected res=%h flags=%b%b%b",
                     result, overflow, underflow, zero, w.res, w.ov, w.uf, w.z);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = observed();
      acc     = in_valid && in_ready;
      if (acc) q.push_back(model(cur));
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (got != 4 || q.size() != 0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_count: got %0d results, %0d pending, out_valid=%b, expected 4/0/0",
               got, q.size(), out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    op_t  opc;
    exp_t w;
    out_ready = 1'b0;
    @(negedge clock);
    drive(rand_op());
    in_valid = 1'b1;
    @(negedge clock);
    drive(rand_op());
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pre_full: got out_valid=%b in_ready=%b, expected 1/0", out_valid, in_ready);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, result, overflow, underflow, zero} !== 36'd0) begin
      n_bad++;
      $display("FAIL rst_async: got valid=%b res=%h flags=%b%b%b, expected all zero",
               out_valid, result, overflow, underflow, zero);
    end
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_stale: got out_valid=%b, expected 0 after reset", out_valid);
    end
    opc = rand_op();
    w   = model(opc);
    drive(opc);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1 || observed() !== w) begin
      n_bad++;
      $display("FAIL rst_first: got valid=%b res=%h flags=%b%b%b, expected valid=1 res=%h flags=%b%b%b",
               out_valid, result, overflow, underflow, zero, w.res, w.ov, w.uf, w.z);
    end
    @(negedge clock);
  endtask

  task automatic test_random(input int n);
    op_t  cur;
    exp_t q[$];
    exp_t w;
    exp_t held;
    int   issued = 0;
    int   got    = 0;
    int   errs   = 0;
    bit   acc    = 0;
    bit   stalled = 0;
    in_valid = 1'b0;
    for (int c = 0; c < n * 6 && got < n; c++) begin
      @(negedge clock);
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || observed() !== held) begin
          n_bad++;
          errs++;
          $display("FAIL rnd_hold: got valid=%b res=%h, expected valid=1 res=%h", out_valid, result, held.res);
        end
      end
      out_ready = ($urandom_range(0, 4) != 0);
      if (acc) in_valid = 1'b0;
      if (!in_valid && issued < n && $urandom_range(0, 4) != 0) begin
        cur = rand_op();
        drive(cur);
        in_valid = 1'b1;
        issued++;
      end
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        got++;
        if (q.size() == 0) begin
          n_bad++;
          errs++;
          $display("FAIL rnd_extra: got res=%h with nothing outstanding", result);
        end else begin
          w = q.pop_front();
          if (observed() !== w) begin
            n_bad++;
            errs++;
            $display("FAIL rnd_data: got res=%h flags=%b%b%b, expected res=%h flags=%b%b%b",
                     result, overflow, underflow, zero, w.res, w.ov, w.uf, w.z);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = observed();
      acc     = in_valid && in_ready;
      if (acc) q.push_back(model(cur));
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != n) begin
      n_bad++;
      errs++;
      $display("FAIL rnd_timeout: got %0d results, expected %0d", got, n);
    end
    $display("test_random: %0d results checked, %0d errors", got, errs);
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random(10000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
